nib_track_ctrl: RTL and testbench

Sequencer between the floppy drive's track buffer and the HPS SD block interface for NIB disk images. Whenever the drive head moves to a new track, or a new image is mounted, it loads that track's 13 × 512-byte sectors into the track RAM. Before loading, it writes back the outgoing track if the drive modified it. It stalls the CPU through `cpu_wait` for the whole transfer and provides the sector index that forms the upper track-RAM address bits.

---
 rtl/nib_track_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nib_track_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nib_track_ctrl.sv
// Track buffer sequencer for NIB images: flushes a modified track back to SD and loads the
// newly selected track, stalling the CPU for the duration of the transfer.
module nib_track_ctrl #(
  parameter int unsigned SECTORS = 13,
  parameter int unsigned TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               track_dirty,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               sd_ack,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StFlushReq,
    StFlushXfer,
    StLoadReq,
    StLoadXfer
  } state_e;

  localparam logic [3:0] LastSec = 4'(SECTORS - 1);

  state_e             state_q, state_d;
  logic [TRACK_W-1:0] cur_track_q, cur_track_d;
  logic [TRACK_W-1:0] tgt_q, tgt_d;
  logic [3:0]         sec_q, sec_d;
  logic               valid_q, valid_d;
  logic               dirty_q, dirty_d;
  logic               mnt_pend_q, mnt_pend_d;
  logic               ack_q;
  logic               ack_rise, ack_fall;
  logic [31:0]        lba_flush, lba_load;

  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;

  assign lba_flush = SECTORS * 32'(cur_track_q) + 32'(sec_q);
  assign lba_load  = SECTORS * 32'(tgt_q) + 32'(sec_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_track_q <= '0;
      tgt_q       <= '0;
      sec_q       <= '0;
      valid_q     <= 1'b0;
      dirty_q     <= 1'b0;
      mnt_pend_q  <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      tgt_q       <= tgt_d;
      sec_q       <= sec_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mnt_pend_q  <= mnt_pend_d;
      ack_q       <= sd_ack;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    tgt_d       = tgt_q;
    sec_d       = sec_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    mnt_pend_d  = mnt_pend_q;

    // A mount seen mid-transfer is deferred until the transfer finishes.
    if (state_q != StIdle && img_mounted) begin
      mnt_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (track_dirty) begin
          dirty_d = 1'b1;
        end
        if (img_mounted || mnt_pend_q) begin
          // The old image's pending write-back is dropped along with the buffer.
          valid_d    = 1'b0;
          dirty_d    = 1'b0;
          mnt_pend_d = 1'b0;
        end else if (!img_present) begin
          state_d = StIdle;
        end else if (dirty_q && valid_q && (track != cur_track_q) && !img_readonly) begin
          sec_d   = '0;
          state_d = StFlushReq;
        end else if (!valid_q || (track != cur_track_q)) begin
          tgt_d   = track;
          sec_d   = '0;
          dirty_d = 1'b0;
          state_d = StLoadReq;
        end
      end

      StFlushReq: begin
        if (ack_rise) begin
          state_d = StFlushXfer;
        end
      end

      StFlushXfer: begin
        if (ack_fall) begin
          if (sec_q == LastSec) begin
            dirty_d = 1'b0;
            sec_d   = '0;
            tgt_d   = track;
            state_d = StLoadReq;
          end else begin
            sec_d   = sec_q + 4'd1;
            state_d = StFlushReq;
          end
        end
      end

      StLoadReq: begin
        if (ack_rise) begin
          state_d = StLoadXfer;
        end
      end

      StLoadXfer: begin
        if (ack_fall) begin
          if (sec_q == LastSec) begin
            cur_track_d = tgt_q;
            valid_d     = 1'b1;
            sec_d       = '0;
            state_d     = StIdle;
          end else begin
            sec_d   = sec_q + 4'd1;
            state_d = StLoadReq;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    sd_lba = '0;
    unique case (state_q)
      StFlushReq: begin
        sd_wr  = 1'b1;
        sd_lba = lba_flush;
      end
      StFlushXfer: sd_lba = lba_flush;
      StLoadReq: begin
        sd_rd  = 1'b1;
        sd_lba = lba_load;
      end
      StLoadXfer: sd_lba = lba_load;
      default: sd_lba = '0;
    endcase
  end

  assign track_sec = sec_q;
  assign busy      = (state_q != StIdle);
  assign cpu_wait  = busy;

endmodule

// File: tb/tb_nib_track_ctrl.sv
// Directed bench for nib_track_ctrl with a simple HPS acknowledge responder that logs every
// sector request for later comparison against hand-computed LBA sequences.
module tb_nib_track_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        track_dirty;
  logic        img_mounted;
  logic        img_present;
  logic        img_readonly;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit hps_hold = 1'b0;
  bit q_wr[$];
  int q_lba[$];
  int q_sec[$];
  int overlap_cnt = 0;
  int wait_falls = 0;
  logic wait_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  nib_track_ctrl #(
    .SECTORS(13),
    .TRACK_W(6)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .track       (track),
    .track_dirty (track_dirty),
    .img_mounted (img_mounted),
    .img_present (img_present),
    .img_readonly(img_readonly),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .track_sec   (track_sec),
    .cpu_wait    (cpu_wait),
    .busy        (busy)
  );

  // HPS model: log the request, then hold sd_ack high for two cycles.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !hps_hold && !reset) begin
        q_wr.push_back(sd_wr);
        q_lba.push_back(int'(sd_lba));
        q_sec.push_back(int'(track_sec));
        @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b0;
        @(negedge clk_sys);
      end
    end
  end

  always @(negedge clk_sys) begin
    if (sd_rd && sd_wr) overlap_cnt <= overlap_cnt + 1;
    if (wait_prev && !cpu_wait) wait_falls <= wait_falls + 1;
    wait_prev <= cpu_wait;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    q_wr.delete();
    q_lba.delete();
    q_sec.delete();
  endtask

  task automatic wait_done(input int n, output bit timed_out);
    int k = 0;
    timed_out = 1'b0;
    @(negedge clk_sys);
    while (!(q_lba.size() >= n && !cpu_wait && !sd_ack)) begin
      @(negedge clk_sys);
      k++;
      if (k > 3000) begin
        timed_out = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic pulse_dirty();
    track_dirty = 1'b1;
    @(negedge clk_sys);
    track_dirty = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    track = 6'd0;
    track_dirty = 1'b0;
    img_mounted = 1'b0;
    img_present = 1'b1;
    img_readonly = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({sd_rd, sd_wr, cpu_wait, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: rd/wr/wait/busy=%b required 0000", {sd_rd, sd_wr, cpu_wait, busy});
    end
    checks++;
    if (sd_lba !== 32'd0) begin
      errors++;
      $display("FAIL reset_lba: got %0d required 0", sd_lba);
    end
    checks++;
    if (track_sec !== 4'd0) begin
      errors++;
      $display("FAIL reset_sec: got %0d required 0", track_sec);
    end
  endtask

  task automatic test_initial_load();
    bit to;
    clear_log();
    reset = 1'b0;
    wait_done(13, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL init_timeout: load did not finish, %0d transfers seen", q_lba.size());
    end
    checks++;
    if (q_lba.size() != 13) begin
      errors++;
      $display("FAIL init_count: got %0d transfers required 13", q_lba.size());
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL init_xfer[%0d]: missing, required rd lba %0d", i, i);
      end else if (q_wr[i] !== 1'b0 || q_lba[i] != i || q_sec[i] != i) begin
        errors++;
        $display("FAIL init_xfer[%0d]: got wr=%0d lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                 i, q_wr[i], q_lba[i], q_sec[i], i, i);
      end
    end
    checks++;
    if (cpu_wait !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_idle: cpu_wait=%b busy=%b required 0 0", cpu_wait, busy);
    end
  endtask

  task automatic test_clean_step();
    bit to;
    clear_log();
    track = 6'd5;
    wait_done(13, to);
    checks++;
    if (to || q_lba.size() != 13) begin
      errors++;
      $display("FAIL clean_count: got %0d transfers (timeout=%0d) required 13", q_lba.size(), to);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL clean_xfer[%0d]: missing, required rd lba %0d", i, 65 + i);
      end else if (q_wr[i] !== 1'b0 || q_lba[i] != 65 + i || q_sec[i] != i) begin
        errors++;
        $display("FAIL clean_xfer[%0d]: got wr=%0d lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                 i, q_wr[i], q_lba[i], q_sec[i], 65 + i, i);
      end
    end
  endtask

  task automatic test_dirty_step();
    bit to;
    int f0;
    int exp_lba;
    bit exp_wr;
    clear_log();
    pulse_dirty();
    f0 = wait_falls;
    track = 6'd6;
    wait_done(26, to);
    checks++;
    if (to || q_lba.size() != 26) begin
      errors++;
      $display("FAIL dirty_count: got %0d transfers (timeout=%0d) required 26", q_lba.size(), to);
    end
    for (int i = 0; i < 26; i++) begin
      exp_wr  = (i < 13);
      exp_lba = (i < 13) ? 65 + i : 78 + (i - 13);
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL dirty_xfer[%0d]: missing, required wr=%0d lba %0d", i, exp_wr, exp_lba);
      end else if (q_wr[i] !== exp_wr || q_lba[i] != exp_lba || q_sec[i] != i % 13) begin
        errors++;
        $display("FAIL dirty_xfer[%0d]: got wr=%0d lba=%0d sec=%0d required wr=%0d lba=%0d sec=%0d",
                 i, q_wr[i], q_lba[i], q_sec[i], exp_wr, exp_lba, i % 13);
      end
    end
    checks++;
    if (wait_falls - f0 != 1) begin
      errors++;
      $display("FAIL dirty_wait: cpu_wait fell %0d times required 1", wait_falls - f0);
    end
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL rd_wr_overlap: %0d cycles with both high required 0", overlap_cnt);
    end
  endtask

  task automatic test_readonly();
    bit to;
    clear_log();
    track = 6'd5;
    wait_done(13, to);
    checks++;
    if (to || q_lba.size() != 13 || q_lba[0] != 65) begin
      errors++;
      $display("FAIL ro_prep: got %0d transfers required 13 from lba 65", q_lba.size());
    end
    clear_log();
    img_readonly = 1'b1;
    pulse_dirty();
    track = 6'd6;
    wait_done(13, to);
    checks++;
    if (to || q_lba.size() != 13) begin
      errors++;
      $display("FAIL ro_count: got %0d transfers (timeout=%0d) required 13", q_lba.size(), to);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL ro_xfer[%0d]: missing, required rd lba %0d", i, 78 + i);
      end else if (q_wr[i] !== 1'b0 || q_lba[i] != 78 + i) begin
        errors++;
        $display("FAIL ro_xfer[%0d]: got wr=%0d lba=%0d required wr=0 lba=%0d",
                 i, q_wr[i], q_lba[i], 78 + i);
      end
    end
    img_readonly = 1'b0;
  endtask

  task automatic test_mid_load();
    bit to;
    int f0;
    int k;
    int exp_lba;
    clear_log();
    f0 = wait_falls;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    k = 0;
    while (!(sd_ack && track_sec == 4'd4) && k < 1000) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (k >= 1000) begin
      errors++;
      $display("FAIL mid_reach: sector 4 of track 6 reload not reached, sec=%0d", track_sec);
    end
    track = 6'd7;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    wait_done(26, to);
    checks++;
    if (to || q_lba.size() != 26) begin
      errors++;
      $display("FAIL mid_count: got %0d transfers (timeout=%0d) required 26", q_lba.size(), to);
    end
    for (int i = 0; i < 26; i++) begin
      exp_lba = (i < 13) ? 78 + i : 91 + (i - 13);
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL mid_xfer[%0d]: missing, required rd lba %0d", i, exp_lba);
      end else if (q_wr[i] !== 1'b0 || q_lba[i] != exp_lba || q_sec[i] != i % 13) begin
        errors++;
        $display("FAIL mid_xfer[%0d]: got wr=%0d lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                 i, q_wr[i], q_lba[i], q_sec[i], exp_lba, i % 13);
      end
    end
    checks++;
    if (wait_falls - f0 != 2) begin
      errors++;
      $display("FAIL mid_gap: cpu_wait fell %0d times required 2", wait_falls - f0);
    end
  endtask

  task automatic test_reset_mid_flush();
    bit to;
    int k;
    clear_log();
    pulse_dirty();
    track = 6'd8;
    k = 0;
    while (!(sd_ack && track_sec == 4'd2) && k < 1000) begin
      @(negedge clk_sys);
      k++;
    end
    hps_hold = 1'b1;
    k = 0;
    while (!(sd_wr && track_sec == 4'd3) && k < 1000) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (k >= 1000 || sd_lba !== 32'd94) begin
      errors++;
      $display("FAIL flush_sec3: sd_wr=%b lba=%0d required 1 and 94", sd_wr, sd_lba);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({sd_rd, sd_wr, cpu_wait, busy} !== 4'b0000 || sd_lba !== 32'd0 || track_sec !== 4'd0) begin
      errors++;
      $display("FAIL rst_flush: rd/wr/wait/busy=%b lba=%0d sec=%0d required 0000 0 0",
               {sd_rd, sd_wr, cpu_wait, busy}, sd_lba, track_sec);
    end
    @(negedge clk_sys);
    clear_log();
    reset = 1'b0;
    hps_hold = 1'b0;
    wait_done(13, to);
    checks++;
    if (to || q_lba.size() != 13) begin
      errors++;
      $display("FAIL rst_reload_count: got %0d transfers (timeout=%0d) required 13",
               q_lba.size(), to);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= q_lba.size()) begin
        errors++;
        $display("FAIL rst_reload[%0d]: missing, required rd lba %0d", i, 104 + i);
      end else if (q_wr[i] !== 1'b0 || q_lba[i] != 104 + i || q_sec[i] != i) begin
        errors++;
        $display("FAIL rst_reload[%0d]: got wr=%0d lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                 i, q_wr[i], q_lba[i], q_sec[i], 104 + i, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_initial_load();
    test_clean_step();
    test_dirty_step();
    test_readonly();
    test_mid_load();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
